// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_arb_pkg                                                     |
// | Shared types, constants and helpers for fifo_wr_arbiter.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package fifo_arb_pkg;

  typedef enum logic {ARB, BURST} arb_state_t;

  localparam int STAT_W = 16;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_wr_arbiter_if                                               |
// | Requester-side and FIFO-write-side signals of the arbiter.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`ifndef DEF_FIFO_WIDTH
`define DEF_FIFO_WIDTH 8
`endif

interface fifo_wr_arbiter_if #(
  parameter int FIFO_WIDTH = `DEF_FIFO_WIDTH,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          full;
  logic                          wr_en;
  logic [FIFO_WIDTH-1:0]         data_in;

  modport master (
    output req, lock, req_data, full,
    input  gnt, wr_en, data_in
  );

  modport slave (
    input  req, lock, req_data, full,
    output gnt, wr_en, data_in
  );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick                                                          |
// | Combinational round-robin picker: first request from i_ptr up.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] i_req,
  input  wire logic [PTR_W-1:0]   i_ptr,
  output logic      [NUM_REQ-1:0] o_onehot,
  output logic      [PTR_W-1:0]   o_idx,
  output logic                    o_any
);

  always_comb begin
    int j;
    j        = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!o_any && i_req[j]) begin
        o_any       = 1'b1;
        o_onehot[j] = 1'b1;
        o_idx       = PTR_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_wr_arbiter                                                  |
// | Round-robin FIFO write-port arbiter with locked bursts.          |
// | Optional macro FIFO_ARB_STATS_EN adds write/stall counters.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`ifndef DEF_FIFO_WIDTH
`define DEF_FIFO_WIDTH 8
`endif

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int FIFO_WIDTH = `DEF_FIFO_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
`ifdef FIFO_ARB_STATS_EN
  output logic [NUM_REQ*STAT_W-1:0]      stat_cnt,
  output logic [STAT_W-1:0]              stall_cnt,
`endif
  fifo_wr_arbiter_if.slave               bus
);

  localparam int   PTR_W    = $clog2(NUM_REQ);
  localparam int   CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic BURST_EN = (MAX_BURST > 1);

  arb_state_t         r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_beat_cnt;

  logic [NUM_REQ-1:0]    w_win_onehot;
  logic [PTR_W-1:0]      w_win_idx;
  logic                  w_win_any;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [FIFO_WIDTH-1:0] w_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_req    (bus.req),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_any    (w_win_any)
  );

  always_comb begin
    w_gnt = '0;
    if (!rst && !bus.full) begin
      if (r_state == ARB) begin
        if (w_win_any) w_gnt = w_win_onehot;
      end else begin
        w_gnt[r_owner] = bus.req[r_owner];
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_data = w_data | bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  assign bus.gnt     = w_gnt;
  assign bus.wr_en   = |w_gnt;
  assign bus.data_in = w_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (!bus.full && w_win_any) begin
            r_rr_ptr <= PTR_W'(rr_next(int'(w_win_idx), NUM_REQ));
            if (bus.lock[w_win_idx] && BURST_EN) begin
              r_state    <= BURST;
              r_owner    <= w_win_idx;
              r_beat_cnt <= CNT_W'(1);
            end
          end
        end
        BURST: begin
          // A full stall freezes the burst; only a dropped request abandons it.
          if (!bus.req[r_owner]) begin
            r_state <= ARB;
          end else if (!bus.full) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if ((int'(r_beat_cnt) + 1 == MAX_BURST) || !bus.lock[r_owner])
              r_state <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst) r_cnt <= '0;
      else if (w_gnt[i] && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
    assign stat_cnt[i*STAT_W +: STAT_W] = r_cnt;
  end

  logic [STAT_W-1:0] r_stall_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_stall_cnt <= '0;
    else if ((|bus.req) && bus.full && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fifo_wr_arbiter                                               |
// | Directed vector bench for fifo_wr_arbiter (4 requesters, burst 4)|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fifo_wr_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.FIFO_WIDTH(W), .NUM_REQ(N)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] stat_cnt;
  logic [15:0]     stall_cnt;
`endif

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .MAX_BURST(B)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FIFO_ARB_STATS_EN
    .stat_cnt  (stat_cnt),
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic       full;
    logic [3:0] gnt;
    int         stall;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] l,
                              input logic f, input logic [3:0] g, input int s);
    vec_t v;
    v.rst = r; v.req = q; v.lock = l; v.full = f; v.gnt = g; v.stall = s;
    vecs.push_back(v);
  endfunction

  function automatic logic [W-1:0] exp_data(input logic [3:0] g);
    case (g)
      4'b0001: return 8'hA0;
      4'b0010: return 8'hA1;
      4'b0100: return 8'hA2;
      4'b1000: return 8'hA3;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    bus.req      = '0;
    bus.lock     = '0;
    bus.full     = 1'b0;
    bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // reset with all requesting
    for (int i = 0; i < 3; i++) add(1, 4'b1111, 4'b0000, 0, 4'b0000, -1);
    // plain round robin
    add(0, 4'b1111, 0, 0, 4'b0001, -1); add(0, 4'b1111, 0, 0, 4'b0010, -1);
    add(0, 4'b1111, 0, 0, 4'b0100, -1); add(0, 4'b1111, 0, 0, 4'b1000, -1);
    add(0, 4'b1111, 0, 0, 4'b0001, -1); add(0, 4'b1111, 0, 0, 4'b0010, -1);
    add(0, 4'b1111, 0, 0, 4'b0100, -1); add(0, 4'b1111, 0, 0, 4'b1000, -1);
    // full stall then release
    for (int i = 0; i < 5; i++) add(0, 4'b0101, 0, 1, 4'b0000, -1);
    add(0, 4'b0101, 0, 0, 4'b0001, 5);
    add(0, 4'b0101, 0, 0, 4'b0100, -1);
    // full 4-beat burst by req0, then req1
    for (int i = 0; i < 4; i++) add(0, 4'b0011, 4'b0001, 0, 4'b0001, -1);
    add(0, 4'b0011, 4'b0000, 0, 4'b0010, -1);
    // lock dropped on beat 2
    add(0, 4'b0011, 4'b0001, 0, 4'b0001, -1);
    add(0, 4'b0011, 4'b0000, 0, 4'b0001, -1);
    add(0, 4'b0011, 4'b0000, 0, 4'b0010, -1);
    // burst stalled by full for 3 cycles keeps its beat count
    add(0, 4'b0011, 4'b0001, 0, 4'b0001, -1);
    for (int i = 0; i < 3; i++) add(0, 4'b0011, 4'b0001, 1, 4'b0000, -1);
    add(0, 4'b0011, 4'b0001, 0, 4'b0001, 8);
    add(0, 4'b0011, 4'b0001, 0, 4'b0001, -1);
    add(0, 4'b0011, 4'b0001, 0, 4'b0001, -1);
    add(0, 4'b0011, 4'b0000, 0, 4'b0010, -1);
    // reset in the middle of a req2 burst
    add(0, 4'b0100, 4'b0100, 0, 4'b0100, -1);
    add(0, 4'b0100, 4'b0100, 0, 4'b0100, -1);
    add(1, 4'b0100, 4'b0100, 0, 4'b0000, -1);
    add(0, 4'b1011, 4'b0000, 0, 4'b0001, -1);
    add(0, 4'b1011, 4'b0000, 0, 4'b0010, -1);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst      = vecs[k].rst;
      bus.req  = vecs[k].req;
      bus.lock = vecs[k].lock;
      bus.full = vecs[k].full;
      #1;
      check($sformatf("v%0d gnt", k), 32'(bus.gnt), 32'(vecs[k].gnt));
      check($sformatf("v%0d wr_en", k), 32'(bus.wr_en), 32'(|vecs[k].gnt));
      check($sformatf("v%0d data_in", k), 32'(bus.data_in), 32'(exp_data(vecs[k].gnt)));
`ifdef FIFO_ARB_STATS_EN
      if (vecs[k].stall >= 0)
        check($sformatf("v%0d stall_cnt", k), 32'(stall_cnt), 32'(vecs[k].stall));
`endif
    end

`ifdef FIFO_ARB_STATS_EN
    @(negedge clk);
    rst = 1'b1; bus.req = '0; bus.lock = '0; bus.full = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("stat_cnt cleared", 32'(stat_cnt), 32'd0);
    check("stall_cnt cleared", 32'(stall_cnt), 32'd0);
    bus.req = 4'b0100;
    for (int i = 0; i < 100; i++) @(negedge clk);
    #1;
    check("stat2 after 100", 32'(stat_cnt[2*16 +: 16]), 32'd100);
    for (int i = 0; i < 69900; i++) @(negedge clk);
    #1;
    check("stat2 saturated", 32'(stat_cnt[2*16 +: 16]), 32'hFFFF);
    check("stat0 untouched", 32'(stat_cnt[0 +: 16]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
